// File: rtl/sirc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sirc_pkg
//  Description : Shared types and timing constants for the SIRC-style IR
//                command transmitter (state encoding, unit counts, frame
//                bit count) plus a small helper for mark durations.
//  Revision    : 1.0 - initial release
// ============================================================================
package sirc_pkg;

    // Frame sequencer states.
    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        START_MARK  = 3'd1,
        START_SPACE = 3'd2,
        BIT_MARK    = 3'd3,
        BIT_SPACE   = 3'd4,
        GAP         = 3'd5
    } sirc_state_e;

    // Durations in timing units.
    localparam int unsigned START_UNITS = 4;
    localparam int unsigned ONE_UNITS   = 2;
    localparam int unsigned ZERO_UNITS  = 1;
    localparam int unsigned SPACE_UNITS = 1;
    localparam int unsigned NBITS       = 12;

    // Index of the last unit of a data-bit mark (0-based), by bit value.
    function automatic logic [1:0] mark_last_unit(input logic i_bit);
        return i_bit ? 2'(ONE_UNITS - 1) : 2'(ZERO_UNITS - 1);
    endfunction

endpackage : sirc_pkg
`default_nettype wire

// File: rtl/sirc_tx_if.sv
`default_nettype none
// ============================================================================
//  Module      : sirc_tx_if
//  Description : Command/strobe and status/output bundle of the SIRC
//                transmitter.
//                  start  : request to send cmd (sampled every cycle)
//                  cmd    : 12-bit command (cmd[6:0] code, cmd[11:7] address)
//                  busy   : frame in progress, including trailing gap
//                  done   : one-cycle pulse when a frame completes
//                  ir_out : mark/space output (carrier-gated when enabled)
//                Modports: master drives start/cmd, slave (transmitter)
//                drives busy/done/ir_out.
//  Revision    : 1.0 - initial release
// ============================================================================
interface sirc_tx_if;

    logic                       start;
    logic [sirc_pkg::NBITS-1:0] cmd;
    logic                       busy;
    logic                       done;
    logic                       ir_out;

    modport master (
        output start,
        output cmd,
        input  busy,
        input  done,
        input  ir_out
    );

    modport slave (
        input  start,
        input  cmd,
        output busy,
        output done,
        output ir_out
    );

endinterface : sirc_tx_if
`default_nettype wire

// File: rtl/sirc_unit_tick.sv
`default_nettype none
// ============================================================================
//  Module      : sirc_unit_tick
//  Description : Restartable prescaler. Counts 0..PERIOD-1 and flags the
//                terminal count (o_tick) and the count just before it
//                (o_pre, always 0 when PERIOD < 2).
//  Ports       : clk, rst_n (sync, active-low), i_restart (count -> 0 on
//                the next edge), o_tick, o_pre.
//  Revision    : 1.0 - initial release
// ============================================================================
module sirc_unit_tick #(
    parameter int unsigned PERIOD = 2
) (
    input  wire  clk,
    input  wire  rst_n,
    input  wire  i_restart,
    output logic o_tick,
    output logic o_pre
);

    localparam int unsigned     c_W    = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [c_W-1:0]  c_LAST = c_W'(PERIOD - 1);
    localparam logic [c_W-1:0]  c_PRE  = (PERIOD >= 2) ? c_W'(PERIOD - 2) : '0;

    logic [c_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_restart || (r_cnt == c_LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tick = (r_cnt == c_LAST);
    assign o_pre  = (PERIOD >= 2) ? (r_cnt == c_PRE) : 1'b0;

endmodule : sirc_unit_tick
`default_nettype wire

// File: rtl/sirc_tx.sv
`default_nettype none
// ============================================================================
//  Module      : sirc_tx
//  Description : 12-bit SIRC-style IR command transmitter. Start mark of 4
//                units, 1-unit space, then 12 bits LSB first, each a mark of
//                2 units (1) or 1 unit (0) followed by a 1-unit space. The
//                frame is padded with a gap so start marks of consecutive
//                frames are exactly FRAME_UNITS units apart.
//  Ports       : clk, rst_n (sync, active-low), bus (sirc_tx_if.slave:
//                start, cmd in; busy, done, ir_out out).
//  Options     : define SIRC_CARRIER_EN to AND the envelope with a square
//                carrier of period 2*CARRIER_HALF; otherwise ir_out is the
//                baseband envelope.
//  Revision    : 1.0 - initial release
// ============================================================================
module sirc_tx
    import sirc_pkg::*;
#(
    parameter int unsigned UNIT_CYCLES  = 30000,
    parameter int unsigned CARRIER_HALF = 625,
    parameter int unsigned FRAME_UNITS  = 75
) (
    input  wire      clk,
    input  wire      rst_n,
    sirc_tx_if.slave bus
);

    localparam int unsigned     c_FW        = $clog2(FRAME_UNITS + 1);
    localparam logic [c_FW-1:0] c_FRAME_END = c_FW'(FRAME_UNITS - 1);

    sirc_state_e      r_state;
    sirc_state_e      w_next;
    logic [1:0]       r_scnt;   // units elapsed in the current state
    logic [c_FW-1:0]  r_fcnt;   // units elapsed since the start-mark edge
    logic [3:0]       r_bcnt;   // bits already sent
    logic [NBITS-1:0] r_sh;

    logic             w_tick;
    logic             w_pre;
    logic             w_restart;
    logic             w_accept;
    logic             w_bit_end;

    logic             w_busy_n;
    logic             w_done_n;
    logic             w_env_n;
    logic             w_ir_n;

    logic             r_busy;
    logic             r_done;
    logic             r_ir;

    // The unit timer runs from 0 in every state; it is held at 0 in IDLE so
    // the first start-mark unit is full length.
    assign w_restart = (w_next != r_state) || (r_state == IDLE);
    assign w_accept  = (r_state == IDLE) && bus.start;
    assign w_bit_end = (r_state == BIT_SPACE) && w_tick &&
                       (r_scnt == 2'(SPACE_UNITS - 1));

    sirc_unit_tick #(
        .PERIOD    (UNIT_CYCLES)
    ) u_unit (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_restart (w_restart),
        .o_tick    (w_tick),
        .o_pre     (w_pre)
    );

    // ------------------------------------------------------------------
    // State register and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_ir    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= w_busy_n;
            r_done  <= w_done_n;
            r_ir    <= w_ir_n;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (bus.start) w_next = START_MARK;
            end
            START_MARK: begin
                if (w_tick && (r_scnt == 2'(START_UNITS - 1))) w_next = START_SPACE;
            end
            START_SPACE: begin
                if (w_tick && (r_scnt == 2'(SPACE_UNITS - 1))) w_next = BIT_MARK;
            end
            BIT_MARK: begin
                if (w_tick && (r_scnt == mark_last_unit(r_sh[0]))) w_next = BIT_SPACE;
            end
            BIT_SPACE: begin
                if (w_bit_end) begin
                    w_next = (r_bcnt == 4'(NBITS - 1)) ? GAP : BIT_MARK;
                end
            end
            GAP: begin
                // Leave one cycle before the last unit ends: the IDLE cycle
                // that follows is the final cycle of the frame, so a held
                // start lands the next start mark exactly FRAME_UNITS later.
                if (w_pre && (r_fcnt >= c_FRAME_END)) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic (next values, registered above)
    // ------------------------------------------------------------------
    always_comb begin
        w_busy_n = (w_next != IDLE);
        w_done_n = (r_state == GAP) && (w_next == IDLE);
        w_env_n  = (w_next == START_MARK) || (w_next == BIT_MARK);
    end

    // ------------------------------------------------------------------
    // Counters and shift register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_scnt <= '0;
            r_fcnt <= '0;
            r_bcnt <= '0;
            r_sh   <= '0;
        end else begin
            if (w_restart) begin
                r_scnt <= '0;
            end else if (w_tick) begin
                r_scnt <= r_scnt + 1'b1;
            end

            if (w_accept) begin
                r_fcnt <= '0;
            end else if (w_tick && (r_state != IDLE) && (r_fcnt < c_FW'(FRAME_UNITS))) begin
                r_fcnt <= r_fcnt + 1'b1;
            end

            if (w_accept) begin
                r_bcnt <= '0;
                r_sh   <= bus.cmd;
            end else if (w_bit_end) begin
                r_bcnt <= r_bcnt + 1'b1;
                r_sh   <= {1'b0, r_sh[NBITS-1:1]};
            end
        end
    end

`ifdef SIRC_CARRIER_EN
    // ------------------------------------------------------------------
    // Carrier: phase restarts high on every mark entry.
    // ------------------------------------------------------------------
    logic w_mark_entry;
    logic w_car_tick;
    logic w_car_n;
    logic r_car;

    assign w_mark_entry = w_env_n && (r_state != START_MARK) && (r_state != BIT_MARK);

    sirc_unit_tick #(
        .PERIOD    (CARRIER_HALF)
    ) u_carrier (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_restart (w_mark_entry),
        .o_tick    (w_car_tick),
        .o_pre     ()
    );

    always_comb begin
        w_car_n = r_car;
        if (w_mark_entry) begin
            w_car_n = 1'b1;
        end else if (w_car_tick) begin
            w_car_n = ~r_car;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_car <= 1'b0;
        end else begin
            r_car <= w_car_n;
        end
    end

    assign w_ir_n = w_env_n & w_car_n;
`else
    assign w_ir_n = w_env_n;
`endif

    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.ir_out = r_ir;

endmodule : sirc_tx
`default_nettype wire
